// File: rtl/ahb_decode_mux.sv
// AHB address decoder and response mux: one-hot slave select from the address
// phase, data-phase response steering, and a two-cycle ERROR default slave.

module ahb_slave_match #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_in,
  input  logic [AW-1:0] base_in,
  input  logic [AW-1:0] mask_in,
  output logic          hit_out
);
  assign hit_out = ((addr_in & mask_in) == (base_in & mask_in));
endmodule

module ahb_decode_mux #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int SLAVE_DEVICES  = 4,
  parameter logic [SLAVE_DEVICES*AHB_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h45683000, 32'h45682000, 32'h45681000, 32'h45680000},
  parameter logic [SLAVE_DEVICES*AHB_ADDR_WIDTH-1:0] SLAVE_MASK =
    {4{32'hFFFFF000}}
) (
  input  logic                                     bus_clk_in,
  input  logic                                     bus_rst_in,
  input  logic [AHB_ADDR_WIDTH-1:0]                bus_addr_in,
  input  logic [1:0]                               bus_trans_in,
  output logic [SLAVE_DEVICES-1:0]                 slave_sel_out,
  input  logic [SLAVE_DEVICES-1:0]                 slave_ready_in,
  input  logic [SLAVE_DEVICES-1:0]                 slave_resp_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0]  slave_rdata_in,
  output logic                                     bus_ready_out,
  output logic                                     bus_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]                bus_rdata_out,
  output logic [7:0]                               decode_err_cnt_out
);

  localparam int IDX_W = (SLAVE_DEVICES > 1) ? $clog2(SLAVE_DEVICES) : 1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  logic [SLAVE_DEVICES-1:0]                     match;
  logic [SLAVE_DEVICES-1:0][AHB_DATA_WIDTH-1:0] rdata_arr;
  logic                                         hit;
  logic [IDX_W-1:0]                             hit_idx;
  logic                                         active, accept, unmapped_act;
  logic                                         unused_trans0;

  ds_state_e        ds_q, ds_d;
  logic             owner_vld_q, owner_vld_d;
  logic [IDX_W-1:0] owner_idx_q, owner_idx_d;
  logic [7:0]       cnt_q, cnt_d;

  for (genvar i = 0; i < SLAVE_DEVICES; i++) begin : g_slv
    ahb_slave_match #(.AW(AHB_ADDR_WIDTH)) u_match (
      .addr_in (bus_addr_in),
      .base_in (SLAVE_BASE[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH]),
      .mask_in (SLAVE_MASK[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH]),
      .hit_out (match[i])
    );
  end

  assign rdata_arr     = slave_rdata_in;
  assign unused_trans0 = bus_trans_in[0];

  // Isolating the lowest set bit gives lowest-index priority on overlaps.
  assign slave_sel_out = match & (~match + SLAVE_DEVICES'(1));

  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = SLAVE_DEVICES - 1; i >= 0; i--)
      if (match[i]) hit_idx = IDX_W'(i);
  end

  assign active       = bus_trans_in[1];
  assign accept       = bus_ready_out;
  assign unmapped_act = active & ~hit;

  always_comb begin
    bus_ready_out = 1'b1;
    bus_resp_out  = 1'b0;
    bus_rdata_out = '0;
    if (owner_vld_q) begin
      bus_ready_out = slave_ready_in[owner_idx_q];
      bus_resp_out  = slave_resp_in[owner_idx_q];
      bus_rdata_out = rdata_arr[owner_idx_q];
    end else begin
      case (ds_q)
        DS_ERR1: begin bus_ready_out = 1'b0; bus_resp_out = 1'b1; end
        DS_ERR2: begin bus_ready_out = 1'b1; bus_resp_out = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_idx_d = owner_idx_q;
    ds_d        = ds_q;
    cnt_d       = cnt_q;
    if (accept) begin
      owner_vld_d = active & hit;
      if (hit) owner_idx_d = hit_idx;
    end
    case (ds_q)
      DS_IDLE: if (accept && unmapped_act) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = (accept && unmapped_act) ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
    // ERR1 never accepts, so every counted event is an entry into ERR1.
    if (accept && unmapped_act && ds_q != DS_ERR1 && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge bus_clk_in) begin
    if (bus_rst_in) begin
      ds_q        <= DS_IDLE;
      owner_vld_q <= 1'b0;
      owner_idx_q <= '0;
      cnt_q       <= 8'd0;
    end else begin
      ds_q        <= ds_d;
      owner_vld_q <= owner_vld_d;
      owner_idx_q <= owner_idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign decode_err_cnt_out = cnt_q;

endmodule
